// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, writeback select codes, control bundle
// and the register-source usage predicates used by hazard logic.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] RD_SEL_ALU = 2'b00;
  localparam logic [1:0] RD_SEL_MEM = 2'b01;
  localparam logic [1:0] RD_SEL_PC4 = 2'b10;

  typedef struct packed {
    logic       register_write_en;
    logic       alu_a;
    logic       alu_b;
    logic       data_write_en;
    logic [3:0] alu_op;
    logic [4:0] branch_op;
    logic [2:0] dm_control;
    logic [1:0] rd_data_sel;
  } ctrl_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: uses_rs1 = 1'b1;
      default:                                           uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
      default:                   uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use check: the load in EX produces its value too late
// for an ID instruction that reads the same register.
module hazard_detect
  import core_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_register_write_en,
  input  logic [1:0] ex_rd_data_sel,
  input  logic [4:0] ex_rd,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       load_use
);

  logic ex_is_load;
  logic rs1_dep;
  logic rs2_dep;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign ex_is_load = ex_valid & ex_register_write_en &
                      (ex_rd_data_sel == RD_SEL_MEM) & (ex_rd != 5'd0);
  assign rs1_dep    = uses_rs1(id_opcode) & (id_rs1 == ex_rd);
  assign rs2_dep    = uses_rs2(id_opcode) & (id_rs2 == ex_rd);
  assign load_use   = ex_is_load & (rs1_dep | rs2_dep);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and a
// saturating bubble counter.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         id_opcode,
  input  logic               id_register_write_en,
  input  logic               id_alu_a,
  input  logic               id_alu_b,
  input  logic               id_data_write_en,
  input  logic [3:0]         id_alu_op,
  input  logic [4:0]         id_branch_op,
  input  logic [2:0]         id_dm_control,
  input  logic [1:0]         id_rd_data_sel,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic               hold_in,
  input  logic               branch_taken,
  output logic               ex_valid,
  output logic               ex_register_write_en,
  output logic               ex_alu_a,
  output logic               ex_alu_b,
  output logic               ex_data_write_en,
  output logic [3:0]         ex_alu_op,
  output logic [4:0]         ex_branch_op,
  output logic [2:0]         ex_dm_control,
  output logic [1:0]         ex_rd_data_sel,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [4:0]         ex_rs1,
  output logic [4:0]         ex_rs2,
  output logic [4:0]         ex_rd,
  output logic               stall_if_id,
  output logic               flush_if_id,
  output logic [COUNT_W-1:0] bubble_count
);

  ctrl_t               id_ctrl;
  ctrl_t               ctrl_reg;
  logic                valid_reg;
  logic [XLEN-1:0]     pc_reg, rs1_data_reg, rs2_data_reg, imm_reg;
  logic [4:0]          rs1_reg, rs2_reg, rd_reg;
  logic [COUNT_W-1:0]  bubble_count_reg;
  logic                load_use;

  assign id_ctrl = '{register_write_en: id_register_write_en,
                     alu_a:             id_alu_a,
                     alu_b:             id_alu_b,
                     data_write_en:     id_data_write_en,
                     alu_op:            id_alu_op,
                     branch_op:         id_branch_op,
                     dm_control:        id_dm_control,
                     rd_data_sel:       id_rd_data_sel};

  hazard_detect u_hazard_detect (
    .ex_valid             (valid_reg),
    .ex_register_write_en (ctrl_reg.register_write_en),
    .ex_rd_data_sel       (ctrl_reg.rd_data_sel),
    .ex_rd                (rd_reg),
    .id_opcode            (id_opcode),
    .id_rs1               (id_rs1),
    .id_rs2               (id_rs2),
    .load_use             (load_use)
  );

  // A taken branch squashes IF/ID, so a pending load-use stall becomes moot.
  assign stall_if_id = hold_in | (load_use & ~branch_taken);
  assign flush_if_id = branch_taken & ~hold_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg        <= 1'b0;
      ctrl_reg         <= '0;
      pc_reg           <= '0;
      rs1_data_reg     <= '0;
      rs2_data_reg     <= '0;
      imm_reg          <= '0;
      rs1_reg          <= '0;
      rs2_reg          <= '0;
      rd_reg           <= '0;
      bubble_count_reg <= '0;
    end else if (!hold_in) begin
      if (branch_taken || load_use) begin
        valid_reg    <= 1'b0;
        ctrl_reg     <= '0;
        pc_reg       <= '0;
        rs1_data_reg <= '0;
        rs2_data_reg <= '0;
        imm_reg      <= '0;
        rs1_reg      <= '0;
        rs2_reg      <= '0;
        rd_reg       <= '0;
        if (bubble_count_reg != '1)
          bubble_count_reg <= bubble_count_reg + COUNT_W'(1);
      end else begin
        valid_reg    <= 1'b1;
        ctrl_reg     <= id_ctrl;
        pc_reg       <= id_pc;
        rs1_data_reg <= id_rs1_data;
        rs2_data_reg <= id_rs2_data;
        imm_reg      <= id_imm;
        rs1_reg      <= id_rs1;
        rs2_reg      <= id_rs2;
        rd_reg       <= id_rd;
      end
    end
  end

  assign ex_valid             = valid_reg;
  assign ex_register_write_en = ctrl_reg.register_write_en;
  assign ex_alu_a             = ctrl_reg.alu_a;
  assign ex_alu_b             = ctrl_reg.alu_b;
  assign ex_data_write_en     = ctrl_reg.data_write_en;
  assign ex_alu_op            = ctrl_reg.alu_op;
  assign ex_branch_op         = ctrl_reg.branch_op;
  assign ex_dm_control        = ctrl_reg.dm_control;
  assign ex_rd_data_sel       = ctrl_reg.rd_data_sel;
  assign ex_pc                = pc_reg;
  assign ex_rs1_data          = rs1_data_reg;
  assign ex_rs2_data          = rs2_data_reg;
  assign ex_imm               = imm_reg;
  assign ex_rs1               = rs1_reg;
  assign ex_rs2               = rs2_reg;
  assign ex_rd                = rd_reg;
  assign bubble_count         = bubble_count_reg;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the segmented RV32I core, directly downstream of the control unit.
- Registers the decoded control bundle, operands, immediate and register addresses into the EX stage.
- Detects load-use hazards and inserts bubbles.
- Applies branch/jump flushes.
- Keeps a saturating bubble counter for performance analysis.

Parameters:
- XLEN, 32, datapath width.
- COUNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_opcode  in  7  opcode of the instruction in ID.
- id_register_write_en, id_alu_a, id_alu_b, id_data_write_en  in  1 each  control unit outputs.
- id_alu_op  in  4  control unit output.
- id_branch_op  in  5  control unit output.
- id_dm_control  in  3  control unit output.
- id_rd_data_sel  in  2  control unit output.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  ID operands and sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5 each  register addresses.
- hold_in  in  1  downstream (memory) wait; freezes this stage.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_* (all control, data and address fields above except opcode)  out  same widths  registered copies.
- stall_if_id  out  1  combinational; hold PC and IF/ID.
- flush_if_id  out  1  combinational; squash IF/ID.
- bubble_count  out  COUNT_W  bubbles inserted since reset.

Behaviour:
- Reset (async, rst=1): all ex_* outputs 0, ex_valid=0, bubble_count=0. The reset state is a bubble.
- Bubble definition: ex_valid=0; ex_register_write_en=0; ex_data_write_en=0; ex_branch_op=5'b00000; every other field 0. No X is ever registered.
- Load-use hazard (combinational), true when all of the following hold:
  - ex_valid=1, ex_register_write_en=1, ex_rd_data_sel=2'b01, ex_rd!=0;
  - and either (uses_rs1(id_opcode) and id_rs1==ex_rd) or (uses_rs2(id_opcode) and id_rs2==ex_rd).
- uses_rs1 is true for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
- uses_rs2 is true for opcodes 0110011, 0100011, 1100011.
- Per rising edge, priority from highest:
  1. hold_in=1: all registers hold, counter holds, branch_taken ignored. The EX stage guarantees it re-asserts branch_taken after the hold clears.
  2. branch_taken=1: load a bubble; counter +1.
  3. load-use hazard: load a bubble; counter +1.
  4. Otherwise: capture all id_* fields, ex_valid=1.
- stall_if_id = hold_in | (load_use & ~branch_taken).
- flush_if_id = branch_taken & ~hold_in.
- Latency: one cycle from ID inputs to ex_* outputs.
- A load followed by a dependent instruction yields exactly one bubble. The second cycle sees ex_valid=0 for that slot, so the hazard clears.
- ex_rd=0 never triggers a hazard.
- A flush while a hazard is pending: the flush wins and stall_if_id=0, because the IF/ID contents are squashed anyway.
- bubble_count saturates at all-ones. It does not wrap.
- Reset asserted mid-hold or mid-stall immediately returns all outputs to reset values.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR);
  - RD_SEL_ALU=2'b00, RD_SEL_MEM=2'b01, RD_SEL_PC4=2'b10;
  - a packed struct ctrl_t for the control bundle;
  - functions uses_rs1 and uses_rs2.
- One sub-module, hazard_detect: purely combinational load-use check. The register, priority logic and counter stay in id_ex_stage.

Test Plan:
- Reset: rst=1 mid-stream with ex_valid=1 → all ex_* outputs 0 immediately; bubble_count=0 after release.
- Load-use: EX holds lw x5 (ex_rd=5, rd_sel=01); ID holds add x6,x5,x7 → stall_if_id=1; next cycle ex_valid=0 and bubble_count=1; following cycle the add is captured with ex_rs1=5.
- No false hazard:
  - ID is jal with id_rs1 field=5 against a load to x5 → no stall.
  - Load to x0 with ID add x1,x0,x0 → no stall.
- Flush: branch_taken=1 with a valid ID instruction → flush_if_id=1; next cycle ex_valid=0, ex_branch_op=0, ex_data_write_en=0; bubble_count increments by 1.
- Hold priority: hold_in=1 together with branch_taken=1 and a load-use hazard → all ex_* outputs unchanged, flush_if_id=0, stall_if_id=1, counter unchanged.
- Saturation: COUNT_W=4, 20 consecutive flushes → bubble_count stops at 15.
